writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: single-entry MEM->WB pipeline register with load alignment/extension,
// sticky misaligned-load detection and a retire counter. Define WB_FWD_EN to add the EX bypass port.
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_flush,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [OFS_W-1:0]  in_ofs,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_wr,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_wd,
  output logic              out_misalign,
  output logic [CNT_W-1:0]  out_retired
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic              accept;
  logic              retire;
  logic              entryValid;
  logic              entryWrite;
  logic              entryMisalign;
  logic [4:0]        entryRd;
  logic [DATA_W-1:0] entryData;
  logic              stickyMisalign;
  logic [CNT_W-1:0]  retireCnt;

  logic [1:0]        effSize;
  logic [2:0]        ofsMask;
  logic              loadMisalign;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keepMask;
  logic              signBit;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] nextData;
  logic              nextMisalign;

  // Held low through reset so the MEM stage never hands over an entry we would lose.
  assign in_ready = rst && (!entryValid || out_ready) && !in_flush;
  assign accept   = in_valid && in_ready;
  assign retire   = entryValid && out_ready && !in_flush;

  // A 32-bit datapath has no doubleword; size 11 degrades to a word access.
  assign effSize = (DATA_W == 32 && in_size == 2'b11) ? 2'b10 : in_size;

  always_comb begin
    ofsMask = 3'b000;
    case (effSize)
      2'b00:   ofsMask = 3'b000;
      2'b01:   ofsMask = 3'b001;
      2'b10:   ofsMask = 3'b011;
      default: ofsMask = 3'b111;
    endcase
  end

  assign loadMisalign = |(3'(in_ofs) & ofsMask);

  assign shifted = in_mem_data >> {in_ofs, 3'b000};

  // Full-width access leaves keepMask all ones, so extension cannot touch the data.
  always_comb begin
    keepMask = '1;
    signBit  = 1'b0;
    case (effSize)
      2'b00: begin
        keepMask = DATA_W'(64'h0000_0000_0000_00FF);
        signBit  = shifted[7];
      end
      2'b01: begin
        keepMask = DATA_W'(64'h0000_0000_0000_FFFF);
        signBit  = shifted[15];
      end
      2'b10: begin
        keepMask = DATA_W'(64'h0000_0000_FFFF_FFFF);
        signBit  = shifted[31];
      end
      default: begin
        keepMask = '1;
        signBit  = 1'b0;
      end
    endcase
  end

  assign loadData     = (shifted & keepMask) | ((in_signed && signBit) ? ~keepMask : '0);
  assign nextData     = in_mem_to_reg ? loadData : in_alu_result;
  assign nextMisalign = in_mem_to_reg && loadMisalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entryValid     <= 1'b0;
      entryWrite     <= 1'b0;
      entryMisalign  <= 1'b0;
      entryRd        <= '0;
      entryData      <= '0;
      stickyMisalign <= 1'b0;
      retireCnt      <= '0;
    end else begin
      if (in_flush) begin
        entryValid <= 1'b0;
      end else if (accept) begin
        entryValid <= 1'b1;
      end else if (retire) begin
        entryValid <= 1'b0;
      end

      if (accept) begin
        entryRd       <= in_rd;
        entryData     <= nextData;
        entryWrite    <= in_reg_write;
        entryMisalign <= nextMisalign;
      end

      if (accept && nextMisalign) begin
        stickyMisalign <= 1'b1;
      end

      if (retire) begin
        retireCnt <= retireCnt + CNT_W'(1);
      end
    end
  end

  assign out_valid    = entryValid;
  assign out_wr       = entryValid && entryWrite && (entryRd != 5'd0) && !entryMisalign;
  assign out_rd       = entryRd;
  assign out_wd       = entryData;
  assign out_misalign = stickyMisalign;
  assign out_retired  = retireCnt;

`ifdef WB_FWD_EN
  assign fwd_valid = out_wr;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_wd;
`endif

endmodule
